tdm_demux8: RTL and testbench
=============================

# tdm_demux8

- Receive end of an 8-slot, 1-bit time-division link whose transmit side is the existing `multiplexer8` driven by a slot counter.
- Deserializes one bit per enabled slot into an 8-bit frame, aligned to a slot-0 `sync` marker.
- Publishes each complete frame on a registered output with a one-cycle valid pulse.
- Flags framing errors and re-hunts for alignment.

## Interface
Parameters:
- none; slot count is fixed at 8 (`SLOTS`, package constant).

Ports (`clock`/`reset_L` named per codebase convention):
- `clock` — input, 1 — sole clock; all state updates on the rising edge.
- `reset_L` — input, 1 — reset; asynchronous, active-low.
- `en` — input, 1 — slot strobe; `din`/`sync` are sampled only when `en`=1.
- `sync` — input, 1 — frame marker; high exactly in slot 0.
- `din` — input, 1 — serial data bit for the current slot.
- `Y` — output, 8 — last complete frame; bit i = slot i value.
- `frame_valid` — output, 1 — one-cycle pulse: `Y` just updated.
- `slot` — output, 3 — next slot index expected.
- `err` — output, 1 — one-cycle pulse on framing error.
- `locked` — output, 1 — high while in RECV.

## Operation
- States: HUNT (unaligned), RECV (aligned). Internal `shadow[6:0]` holds slots 0–6 of the frame in progress.
- Reset (async assert) sets:
  - state=HUNT, `slot`=0, `shadow`=0
  - `Y`=8'h00, `frame_valid`=0, `err`=0, `locked`=0
- `en`=0: all state held; `frame_valid`/`err` deassert.
- HUNT, `en`=1:
  - `sync`=1: `shadow[0]`←`din`, `slot`←1, go RECV.
  - `sync`=0: bit discarded, stay in HUNT, no `err`.
- RECV, `en`=1:
  - `slot`=0, `sync`=1: `shadow[0]`←`din`, `slot`←1 (normal frame start).
  - `slot`=0, `sync`=0: `err` pulse, go HUNT, `slot`←0; `Y` unchanged.
  - `slot`≠0, `sync`=1: `err` pulse, resync in place: `shadow[0]`←`din`, `slot`←1, stay in RECV. The partial frame is discarded.
  - `slot` in 1..6, `sync`=0: `shadow[slot]`←`din`, `slot`←`slot`+1.
  - `slot`=7, `sync`=0: `Y`←{`din`, `shadow[6:0]`}, `frame_valid` pulse, `slot` wraps to 0, stay in RECV.
- `slot` arithmetic is 3-bit modulo 8; wrap is 7→0 only on the completing strobe.
- `err` and `frame_valid` are never high in the same cycle.

## Timing
- Registered outputs: `Y`, `frame_valid`, `err`, `slot`, `locked` all change only at a clock edge or on async reset.
- Latency: `Y`/`frame_valid` appear the cycle after the edge that samples slot 7. First frame after lock needs 8 enabled strobes.
- Back-to-back frames: with `en` held high, `frame_valid` pulses every 8 cycles.
- `en` gaps of any length mid-frame are legal. Frame content is unaffected.
- Reset asserted mid-frame: partial frame lost, `Y` cleared immediately (asynchronous). After `reset_L` rises, the first edge acts from HUNT.
- Inputs are synchronous to `clock`; no internal synchronizer.

## Structure
- Package `tdm_pkg`:
  - `localparam SLOTS = 8`
  - `typedef enum logic {HUNT, RECV} tdm_state_t`
  - `typedef logic [2:0] slot_t`
- One sub-module: `slot_counter`.
  - 3-bit counter with `en`, synchronous `load1` (set to 1) and `clr` (set to 0), async active-low reset.
  - Instantiated once for `slot`.
- Shadow register, output register and FSM live in `tdm_demux8`. No latches: use always_ff / always_comb only.

## Test plan
- Loopback:
  - Stimulus: counter drives `multiplexer8` S with I = 8'hA5, `sync`=(S==0), `en`=1, 24 cycles.
  - Required: `frame_valid` every 8 cycles, `Y`=8'hA5 each time, `err` never set.
- HUNT discard:
  - Stimulus: 3 strobes with `sync`=0, then a frame of 8'h3C.
  - Required: no `err`, `locked` rises after the `sync` strobe, `Y`=8'h3C.
- Early sync:
  - Stimulus: `sync` asserted at slot 4.
  - Required: `err` 1-cycle pulse, `slot`=1 next cycle, following 7 bits complete a new frame, `Y` = the new frame.
- Missing sync:
  - Stimulus: `sync`=0 at slot 0 after a good frame.
  - Required: `err` pulse, `locked`=0, `Y` retains the prior value.
- `en` gaps:
  - Stimulus: frame 8'h81 with `en` low for 5 cycles between slots 3 and 4.
  - Required: `Y`=8'h81, one `frame_valid`.
- Reset mid-frame:
  - Stimulus: drop `reset_L` between clock edges at slot 5.
  - Required: `Y`=0, `slot`=0, `locked`=0 immediately; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux8_pkg.sv
// Shared types and constants for the 8-slot TDM receive path.
package tdm_pkg;

  localparam int SLOTS = 8;

  typedef enum logic {HUNT, RECV} tdm_state_t;

  typedef logic [2:0] slot_t;

endpackage

// File: rtl/tdm_demux8_if.sv
// Bus bundle between the TDM line side and the frame consumer.
//
// Strobe/pulse semantics: en is the only qualifier on the line side. sync and
// din mean nothing unless en=1, and there is no back-pressure. On the frame
// side, frame_valid is a one-cycle pulse marking the cycle in which Y holds a
// newly completed frame. The consumer must take it in that cycle, because
// there is no ready. err is a one-cycle pulse and is never high together with
// frame_valid.
interface tdm_demux8_if;
  import tdm_pkg::*;

  logic       en;
  logic       sync;
  logic       din;
  logic [7:0] Y;
  logic       frame_valid;
  slot_t      slot;
  logic       err;
  logic       locked;
  tdm_state_t state;

  modport master (
    output en, sync, din,
    input  Y, frame_valid, slot, err, locked, state
  );

  modport slave (
    input  en, sync, din,
    output Y, frame_valid, slot, err, locked, state
  );

endinterface

// File: rtl/tdm_demux8_slot_counter.sv
// 3-bit slot index counter. Priority order is clr, then load1, then en.
module slot_counter
  import tdm_pkg::*;
(
  input  logic  clock,
  input  logic  reset_L,
  input  logic  en,
  input  logic  load1,
  input  logic  clr,
  output slot_t q
);

  // Counter register; increment wraps 7 -> 0 naturally in 3 bits.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load1) begin
      q <= 3'd1;
    end else if (en) begin
      q <= q + 3'd1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of an 8-slot, 1-bit TDM link. It aligns to the slot-0 sync
// marker, deserializes one bit per enabled slot and publishes each complete
// frame on Y with a one-cycle frame_valid pulse.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic          clock,
  input  logic          reset_L,
  tdm_demux8_if.slave   bus
);

  tdm_state_t state_q, state_d;
  logic [6:0] shadow_q, shadow_d;
  logic [7:0] y_q, y_d;
  logic       fv_q, fv_d;
  logic       err_q, err_d;
  logic       cnt_inc, cnt_load1, cnt_clr;
  slot_t      slot_q;

  slot_counter u_slot (
    .clock   (clock),
    .reset_L (reset_L),
    .en      (cnt_inc),
    .load1   (cnt_load1),
    .clr     (cnt_clr),
    .q       (slot_q)
  );

  // State, shadow, output frame and pulse registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  // Next-state, shadow capture, frame completion and error detection.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          // Bits before the first marker are discarded without complaint.
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            cnt_load1   = 1'b1;
            state_d     = RECV;
          end
        end
        RECV: begin
          if (bus.sync) begin
            // A marker anywhere other than slot 0 restarts the frame in place.
            shadow_d[0] = bus.din;
            cnt_load1   = 1'b1;
            err_d       = (slot_q != 3'd0);
          end else if (slot_q == 3'd0) begin
            // Missing marker: alignment lost, so go back to hunting.
            err_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = HUNT;
          end else if (slot_q == 3'd7) begin
            y_d     = {bus.din, shadow_q};
            fv_d    = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            shadow_d[slot_q] = bus.din;
            cnt_inc          = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign bus.Y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.err         = err_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == RECV);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a vector table for hunt and loopback, then
// hand-written sequences for the multi-cycle corner cases.
module tb_tdm_demux8;
  import tdm_pkg::*;

  typedef struct {
    logic       en;
    logic       sync;
    logic       din;
    logic [7:0] y;
    logic       fv;
    logic       err;
    logic [2:0] slot;
    logic       locked;
  } vec_t;

  logic clock;
  logic reset_L;
  int   n_cmp;
  int   n_fail;
  vec_t vecs[$];

  tdm_demux8_if bus ();

  tdm_demux8 dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  // Clock and reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic sync, input logic din,
                     input logic [7:0] y, input logic fv, input logic err,
                     input logic [2:0] slot, input logic locked);
    vec_t v;
    v.en = en; v.sync = sync; v.din = din; v.y = y; v.fv = fv;
    v.err = err; v.slot = slot; v.locked = locked;
    vecs.push_back(v);
  endtask

  // Driver: apply one cycle of inputs, then settle just past the edge.
  task automatic drive(input logic en, input logic sync, input logic din);
    bus.en = en; bus.sync = sync; bus.din = din;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, v[i]);
  endtask

  initial begin
    logic [7:0] f3c;
    logic [7:0] fa5;
    logic [7:0] f96;
    logic [7:0] f81;
    logic [7:0] fc3;
    logic [7:0] f5a;
    int         s;
    int         fv_cnt;

    n_cmp = 0; n_fail = 0;
    f3c = 8'h3C; fa5 = 8'hA5; f96 = 8'h96; f81 = 8'h81; fc3 = 8'hC3; f5a = 8'h5A;

    // Table: three discarded bits in HUNT, a 3C frame, then a 24-cycle A5 loopback.
    add(1, 0, 1, 8'h00, 0, 0, 3'd0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 3'd0, 0);
    add(1, 0, 1, 8'h00, 0, 0, 3'd0, 0);
    for (int i = 0; i < 8; i++)
      add(1, i == 0, f3c[i], (i == 7) ? 8'h3C : 8'h00, i == 7, 0, 3'((i + 1) % 8), 1);
    for (int c = 0; c < 24; c++) begin
      s = c % 8;
      add(1, s == 0, fa5[s], (c < 7) ? 8'h3C : 8'hA5, s == 7, 0, 3'((s + 1) % 8), 1);
    end

    bus.en = 1'b0; bus.sync = 1'b0; bus.din = 1'b0;
    reset_L = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_y", bus.Y, 8'h00);
    chk("rst_slot", {5'd0, bus.slot}, 8'd0);
    chk("rst_locked", {7'd0, bus.locked}, 8'd0);
    chk("rst_fv", {7'd0, bus.frame_valid}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    @(negedge clock);
    reset_L = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].en, vecs[k].sync, vecs[k].din);
      chk($sformatf("vec%0d_y", k), bus.Y, vecs[k].y);
      chk($sformatf("vec%0d_fv", k), {7'd0, bus.frame_valid}, {7'd0, vecs[k].fv});
      chk($sformatf("vec%0d_err", k), {7'd0, bus.err}, {7'd0, vecs[k].err});
      chk($sformatf("vec%0d_slot", k), {5'd0, bus.slot}, {5'd0, vecs[k].slot});
      chk($sformatf("vec%0d_locked", k), {7'd0, bus.locked}, {7'd0, vecs[k].locked});
    end

    // Missing sync at slot 0 after a good frame.
    drive(1'b1, 1'b0, 1'b1);
    chk("miss_err", {7'd0, bus.err}, 8'd1);
    chk("miss_locked", {7'd0, bus.locked}, 8'd0);
    chk("miss_y", bus.Y, 8'hA5);
    chk("miss_slot", {5'd0, bus.slot}, 8'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk("miss_err_clear", {7'd0, bus.err}, 8'd0);

    // Early sync at slot 4 restarts the frame.
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b1);
    chk("early_pre_slot", {5'd0, bus.slot}, 8'd4);
    chk("early_pre_err", {7'd0, bus.err}, 8'd0);
    drive(1'b1, 1'b1, f96[0]);
    chk("early_err", {7'd0, bus.err}, 8'd1);
    chk("early_slot", {5'd1, bus.slot} & 8'h07, 8'd1);
    chk("early_locked", {7'd0, bus.locked}, 8'd1);
    chk("early_fv", {7'd0, bus.frame_valid}, 8'd0);
    drive(1'b1, 1'b0, f96[1]);
    chk("early_err_clear", {7'd0, bus.err}, 8'd0);
    for (int i = 2; i < 8; i++) drive(1'b1, 1'b0, f96[i]);
    chk("early_y", bus.Y, 8'h96);
    chk("early_fv_end", {7'd0, bus.frame_valid}, 8'd1);
    chk("early_err_end", {7'd0, bus.err}, 8'd0);

    // en gap of 5 cycles between slots 3 and 4; inputs toggle meanwhile.
    fv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, f81[i]);
      if (bus.frame_valid) fv_cnt++;
    end
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, g[0], ~g[0]);
      if (bus.frame_valid) fv_cnt++;
      chk($sformatf("gap%0d_slot", g), {5'd0, bus.slot}, 8'd4);
      chk($sformatf("gap%0d_err", g), {7'd0, bus.err}, 8'd0);
    end
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 1'b0, f81[i]);
      if (bus.frame_valid) fv_cnt++;
    end
    chk("gap_y", bus.Y, 8'h81);
    drive(1'b0, 1'b0, 1'b0);
    if (bus.frame_valid) fv_cnt++;
    chk("gap_fv_count", 8'(fv_cnt), 8'd1);

    // Reset mid-frame at slot 5.
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, fc3[i]);
    chk("rmid_pre_slot", {5'd0, bus.slot}, 8'd5);
    @(negedge clock);
    reset_L = 1'b0;
    #1;
    chk("rmid_y", bus.Y, 8'h00);
    chk("rmid_slot", {5'd0, bus.slot}, 8'd0);
    chk("rmid_locked", {7'd0, bus.locked}, 8'd0);
    @(posedge clock);
    #2;
    reset_L = 1'b1;
    send_frame(f5a);
    chk("rpost_y", bus.Y, 8'h5A);
    chk("rpost_fv", {7'd0, bus.frame_valid}, 8'd1);
    chk("rpost_locked", {7'd0, bus.locked}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
